// File: rtl/l_type_unit_if.sv
// l_type_unit_if: instruction/data bus between the core and the load unit
interface l_type_unit_if;
  logic [31:0] idata;
  logic [31:0] iaddr;
  logic [31:0] imm;
  logic [31:0] rv1;
  logic [31:0] rv2;
  logic [31:0] daddr;
  logic [31:0] drdata;
  logic [31:0] ld_addr;
  logic [31:0] regdata_L;
  logic        ld_misaligned;
  logic        ld_illegal;
  logic [31:0] regdata_L_q;
  logic        ld_valid_q;
  modport master (
    output idata, iaddr, imm, rv1, rv2, daddr, drdata,
    input  ld_addr, regdata_L, ld_misaligned, ld_illegal, regdata_L_q, ld_valid_q
  );
  modport slave (
    input  idata, iaddr, imm, rv1, rv2, daddr, drdata,
    output ld_addr, regdata_L, ld_misaligned, ld_illegal, regdata_L_q, ld_valid_q
  );
endinterface

// File: rtl/l_type_unit.sv
// l_type_unit: RV32I load decode, byte/half/word extraction and extension, registered copy
module l_type_unit #(
  parameter int         XLEN        = 32,
  parameter logic [6:0] LOAD_OPCODE = 7'b0000011
) (
  input logic          clk,
  input logic          reset,
  l_type_unit_if.slave bus
);
  logic [2:0]      w_f3;
  logic [1:0]      w_off;
  logic [XLEN-1:0] w_shift;
  logic [7:0]      w_byte;
  logic [15:0]     w_half;
  logic            w_is_load;
  logic            w_unused;
  logic [31:0]     r_data;
  logic            r_valid;
  assign w_f3      = bus.idata[14:12];
  assign w_off     = bus.daddr[1:0];
  assign w_is_load = bus.idata[6:0] == LOAD_OPCODE;
  assign w_shift   = bus.drdata >> {w_off, 3'b000};
  assign w_byte    = w_shift[7:0];
  assign w_half    = w_off[1] ? bus.drdata[31:16] : bus.drdata[15:0];
  assign w_unused  = ^{bus.iaddr, bus.rv2, bus.idata[31:15], bus.idata[11:7], bus.daddr[31:2]};
  assign bus.ld_addr = bus.rv1 + bus.imm;
  // misaligned accesses keep the normal data path; only the flag changes
  always_comb begin
    bus.regdata_L     = '0;
    bus.ld_illegal    = 1'b0;
    bus.ld_misaligned = 1'b0;
    case (w_f3)
      3'b000: bus.regdata_L = {{24{w_byte[7]}}, w_byte};
      3'b100: bus.regdata_L = {24'h0, w_byte};
      3'b001: begin
        bus.regdata_L     = {{16{w_half[15]}}, w_half};
        bus.ld_misaligned = w_off[0];
      end
      3'b101: begin
        bus.regdata_L     = {16'h0, w_half};
        bus.ld_misaligned = w_off[0];
      end
      3'b010: begin
        bus.regdata_L     = bus.drdata;
        bus.ld_misaligned = w_off != 2'b00;
      end
      default: bus.ld_illegal = 1'b1;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_data  <= bus.regdata_L;
      r_valid <= w_is_load & ~bus.ld_illegal & ~bus.ld_misaligned;
    end
  end
  assign bus.regdata_L_q = r_data;
  assign bus.ld_valid_q  = r_valid;
endmodule

// File: tb/tb_l_type_unit.sv
// tb_l_type_unit: directed and randomized checks of l_type_unit against an arithmetic load model
module tb_l_type_unit;
  logic clk = 1'b0;
  logic reset;
  int checks = 0;
  int errors = 0;
  l_type_unit_if bus();
  l_type_unit dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  f3;
    int          off;
    logic [31:0] d;
    logic [31:0] exp;
    logic        mis;
  } vec_t;

  // returns {illegal, misaligned, data}
  function automatic logic [33:0] model(input logic [2:0] f3, input int off, input logic [31:0] d);
    int unsigned b, h;
    b = (d >> (8 * off)) & 32'hFF;
    h = (off >= 2) ? (d >> 16) : (d & 32'hFFFF);
    case (f3)
      3'd0: return {2'b00, (b >= 128) ? b + 32'hFFFFFF00 : b};
      3'd4: return {2'b00, b};
      3'd1: return {1'b0, off % 2 != 0, (h >= 32768) ? h + 32'hFFFF0000 : h};
      3'd5: return {1'b0, off % 2 != 0, h};
      3'd2: return {1'b0, off != 0, d};
      default: return {2'b10, 32'h0};
    endcase
  endfunction

  task automatic drive(input logic [2:0] f3, input int off, input logic [31:0] d, input logic [6:0] op);
    logic [31:0] r;
    r = $urandom;
    bus.idata  = {r[31:15], f3, r[11:7], op};
    r = $urandom;
    bus.daddr  = {r[31:2], 2'(off)};
    bus.drdata = d;
    bus.iaddr  = $urandom;
    bus.rv2    = $urandom;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.rv1 = 32'h0;
    bus.imm = 32'h0;
    drive(3'd2, 0, 32'hA5A5A5A5, 7'b0000011);
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.regdata_L_q !== 32'h0 || bus.ld_valid_q !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: q=%h valid=%b, expected 0/0", bus.regdata_L_q, bus.ld_valid_q);
    end
    reset = 1'b0;
  endtask

  task automatic test_directed();
    vec_t v[9];
    v[0] = '{3'd0, 2, 32'hFFFFFFF0, 32'hFFFFFFFF, 1'b0};
    v[1] = '{3'd0, 2, 32'hFF7FFFF0, 32'h0000007F, 1'b0};
    v[2] = '{3'd1, 2, 32'hFF7FFFF0, 32'hFFFFFF7F, 1'b0};
    v[3] = '{3'd5, 2, 32'hFF7FFFF0, 32'h0000FF7F, 1'b0};
    v[4] = '{3'd1, 0, 32'hFF7FFFF0, 32'hFFFFFFF0, 1'b0};
    v[5] = '{3'd1, 1, 32'hFF7FFFF0, 32'hFFFFFFF0, 1'b1};
    v[6] = '{3'd2, 0, 32'hFF7FFFF0, 32'hFF7FFFF0, 1'b0};
    v[7] = '{3'd2, 2, 32'hFF7FFFF0, 32'hFF7FFFF0, 1'b1};
    v[8] = '{3'd4, 3, 32'hFF7FFFF0, 32'h000000FF, 1'b0};
    foreach (v[i]) begin
      drive(v[i].f3, v[i].off, v[i].d, 7'b0000011);
      checks++;
      if (bus.regdata_L !== v[i].exp || bus.ld_misaligned !== v[i].mis || bus.ld_illegal !== 1'b0) begin
        errors++;
        $display("FAIL directed_comb[%0d]: data=%h mis=%b ill=%b, expected %h/%b/0",
                 i, bus.regdata_L, bus.ld_misaligned, bus.ld_illegal, v[i].exp, v[i].mis);
      end
      @(posedge clk);
      #1;
      checks++;
      if (bus.regdata_L_q !== v[i].exp || bus.ld_valid_q !== !v[i].mis) begin
        errors++;
        $display("FAIL directed_q[%0d]: q=%h valid=%b, expected %h/%b",
                 i, bus.regdata_L_q, bus.ld_valid_q, v[i].exp, !v[i].mis);
      end
    end
  endtask

  task automatic test_illegal();
    logic [2:0] f[3] = '{3'd3, 3'd6, 3'd7};
    foreach (f[i]) begin
      drive(f[i], int'($urandom_range(0, 3)), $urandom, 7'b0000011);
      checks++;
      if (bus.regdata_L !== 32'h0 || bus.ld_illegal !== 1'b1 || bus.ld_misaligned !== 1'b0) begin
        errors++;
        $display("FAIL illegal_comb[f3=%0d]: data=%h ill=%b mis=%b, expected 0/1/0",
                 f[i], bus.regdata_L, bus.ld_illegal, bus.ld_misaligned);
      end
      @(posedge clk);
      #1;
      checks++;
      if (bus.ld_valid_q !== 1'b0 || bus.regdata_L_q !== 32'h0) begin
        errors++;
        $display("FAIL illegal_q[f3=%0d]: valid=%b q=%h, expected 0/0", f[i], bus.ld_valid_q, bus.regdata_L_q);
      end
    end
  endtask

  task automatic test_addr();
    logic [31:0] a[4] = '{32'h00001000, 32'hFFFFFFFF, 32'h0, 32'h0};
    logic [31:0] b[4] = '{32'hFFFFFFFC, 32'h00000001, 32'h0, 32'h0};
    logic [31:0] e[4] = '{32'h00000FFC, 32'h00000000, 32'h0, 32'h0};
    for (int i = 2; i < 4; i++) begin
      a[i] = $urandom;
      b[i] = $urandom;
      e[i] = 32'((longint'(a[i]) + longint'(b[i])) % 64'h1_0000_0000);
    end
    foreach (a[i]) begin
      bus.rv1 = a[i];
      bus.imm = b[i];
      #1;
      checks++;
      if (bus.ld_addr !== e[i]) begin
        errors++;
        $display("FAIL ld_addr[%0d]: got %h, expected %h", i, bus.ld_addr, e[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [33:0] m;
    logic [2:0]  f3;
    logic [6:0]  op;
    logic [31:0] d;
    int          off;
    logic        exp_valid;
    for (int i = 0; i < 200; i++) begin
      f3  = 3'($urandom_range(0, 7));
      off = int'($urandom_range(0, 3));
      d   = $urandom;
      op  = ($urandom_range(0, 3) == 0) ? 7'($urandom) : 7'b0000011;
      drive(f3, off, d, op);
      m = model(f3, off, d);
      exp_valid = (op == 7'b0000011) && !m[33] && !m[32];
      checks++;
      if (bus.regdata_L !== m[31:0] || bus.ld_misaligned !== m[32] || bus.ld_illegal !== m[33]) begin
        errors++;
        $display("FAIL random_comb[%0d] f3=%0d off=%0d d=%h: data=%h mis=%b ill=%b, expected %h/%b/%b",
                 i, f3, off, d, bus.regdata_L, bus.ld_misaligned, bus.ld_illegal, m[31:0], m[32], m[33]);
      end
      @(posedge clk);
      #1;
      checks++;
      if (bus.regdata_L_q !== m[31:0] || bus.ld_valid_q !== exp_valid) begin
        errors++;
        $display("FAIL random_q[%0d]: q=%h valid=%b, expected %h/%b",
                 i, bus.regdata_L_q, bus.ld_valid_q, m[31:0], exp_valid);
      end
    end
  endtask

  task automatic test_reset_mid();
    drive(3'd2, 0, 32'h12345678, 7'b0000011);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (bus.regdata_L_q !== 32'h0 || bus.ld_valid_q !== 1'b0 || bus.regdata_L !== 32'h12345678) begin
      errors++;
      $display("FAIL reset_mid: q=%h valid=%b comb=%h, expected 0/0/12345678",
               bus.regdata_L_q, bus.ld_valid_q, bus.regdata_L);
    end
    reset = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (bus.regdata_L_q !== 32'h12345678 || bus.ld_valid_q !== 1'b1) begin
      errors++;
      $display("FAIL reset_resume: q=%h valid=%b, expected 12345678/1", bus.regdata_L_q, bus.ld_valid_q);
    end
  endtask

  initial begin
    @(posedge clk);
    #1;
    test_reset();
    test_directed();
    test_illegal();
    test_addr();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/l_type_unit.md
Name: l_type_unit

Overview:
- Load-instruction unit (RV32I L-type: LB, LH, LW, LBU, LHU) of the single-cycle core, attached to the shared Instr_IO instruction bus.
- Decodes funct3 from the current instruction word and computes the load effective address.
- Extracts and sign- or zero-extends the addressed byte, halfword or word from the memory read word, producing the writeback value combinationally.
- Registers a copy of the result plus status flags for debug and pipeline observation.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- LOAD_OPCODE, 7'b0000011, opcode value that qualifies a load.

Ports:
- clk  input  1  system clock; one clock domain.
- reset  input  1  synchronous, active-high reset.
- idata  input  32  current instruction; [6:0] opcode, [14:12] funct3.
- iaddr  input  32  PC of the instruction; unused, carried on the bus only.
- imm  input  32  signed I-type immediate.
- rv1  input  32  signed base register value (rs1).
- rv2  input  32  rs2 value; unused.
- daddr  input  32  data address of the current access; [1:0] is the byte offset.
- drdata  input  32  word read from data memory, aligned to daddr[31:2].
- ld_addr  output  32  effective address, rv1+imm.
- regdata_L  output  32  extracted and extended load result (combinational).
- ld_misaligned  output  1  combinational misaligned-access flag.
- ld_illegal  output  1  combinational illegal-funct3 flag.
- regdata_L_q  output  32  regdata_L registered on clk.
- ld_valid_q  output  1  registered: previous cycle was a legal, aligned load.

Behaviour:
- Interface: one clock domain, clk; reset is synchronous and active-high.
- is_load = (idata[6:0] == LOAD_OPCODE).
- The combinational outputs (ld_addr, regdata_L, ld_misaligned, ld_illegal) are computed regardless of is_load; the writeback mux outside this block selects them.
- ld_addr = rv1 + imm, modulo 2^32; wrap-around is ignored.
- Let off = daddr[1:0].
  - Byte = drdata[8*off+7 : 8*off].
  - Half = drdata[31:16] if off[1] is 1, else drdata[15:0].
- funct3 decode:
  - 000 LB: regdata_L = sign-extended byte.
  - 100 LBU: regdata_L = zero-extended byte.
  - 001 LH: regdata_L = sign-extended half.
  - 101 LHU: regdata_L = zero-extended half.
  - 010 LW: regdata_L = drdata.
  - 011, 110, 111: regdata_L = 0, ld_illegal = 1.
- Misalignment:
  - ld_misaligned = 1 for LH or LHU with off[0] = 1.
  - ld_misaligned = 1 for LW with off != 0.
  - The data path is unchanged when misaligned: the half is still selected by off[1], and LW still returns drdata.
  - Bytes are never misaligned.
- ld_illegal and ld_misaligned are 0 for legal, aligned funct3.
- Combinational path: a change on any input must be reflected on the combinational outputs within the same cycle, with no clock edge required.
- Registered outputs, on each rising clk edge:
  - If reset: regdata_L_q = 0 and ld_valid_q = 0.
  - Otherwise: regdata_L_q = regdata_L, and ld_valid_q = is_load & ~ld_illegal & ~ld_misaligned.
- Reset mid-operation: reset has priority over capture in that cycle. Combinational outputs are unaffected by reset.
- No state machine and no handshake; latency is 0 cycles for combinational outputs and 1 cycle for the _q outputs.

Test Plan:
- LB sign: idata funct3=000, opcode=0000011, daddr=0x00100002, drdata=0xFFFFFFF0 -> regdata_L=0xFFFFFFFF; flags 0.
  - Same, drdata=0xFF7FFFF0 -> regdata_L=0x0000007F.
  - After the next clk: regdata_L_q=0x0000007F, ld_valid_q=1.
- LH/LHU: daddr offset 2, drdata=0xFF7FFFF0:
  - LH -> 0xFFFFFF7F.
  - LHU -> 0x0000FF7F.
  - offset 0, LH -> 0xFFFFFFF0.
  - offset 1 -> ld_misaligned=1.
- LW/LBU: drdata=0xFF7FFFF0:
  - LW offset 0 -> 0xFF7FFFF0, aligned.
  - LW offset 2 -> ld_misaligned=1, regdata_L=0xFF7FFFF0, and after the clk ld_valid_q=0.
  - LBU offset 3 -> 0x000000FF.
- Illegal: funct3 011, 110 and 111 -> regdata_L=0, ld_illegal=1, ld_valid_q=0 after the clk.
- Address: rv1=0x00001000, imm=0xFFFFFFFC -> ld_addr=0x00000FFC; rv1=0xFFFFFFFF, imm=1 -> ld_addr=0 (wrap).
- Reset: load a value so regdata_L_q is nonzero, then assert reset for one clk -> regdata_L_q=0 and ld_valid_q=0, while regdata_L still shows the extracted value. Deassert reset -> capture resumes on the next edge.
